// File: rtl/cache_axi_rd_arbiter_pkg.sv
// Shared types and constants for the cache-side AXI read arbiter.
// Contents: FSM state enum, AXI AR encodings and the default line type.
package cache_arb_pkg;

  localparam int unsigned LINE_WORD_NUM_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    AR    = 2'd1,
    RDATA = 2'd2,
    RET   = 2'd3
  } arb_state_t;

  localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  typedef logic [32*LINE_WORD_NUM_DEF-1:0] line_t;

endpackage

// File: rtl/cache_axi_rd_arbiter_if.sv
// AXI4 read address / read data channel bundle.
// master: drives AR fields, arvalid and rready; slave: drives arready and R fields.
interface cache_axi_rd_arbiter_if #(
  parameter int unsigned ID_WIDTH = 4
);
  logic [ID_WIDTH-1:0] arid;
  logic [31:0]         araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arvalid;
  logic                arready;
  logic [ID_WIDTH-1:0] rid;
  logic [31:0]         rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/cache_axi_rd_arbiter_req_arbiter.sv
// Request arbiter: picks one requester index from the request vector.
// Ports: req (request levels), grant (winning index), any (some request high);
// with CACHE_ARB_RR_EN also clk/rst_n, update (advance pointer) and last (served index).
// Macro CACHE_ARB_RR_EN selects round-robin; otherwise fixed priority, lowest index wins.
module req_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 2
) (
`ifdef CACHE_ARB_RR_EN
  input  logic               clk,
  input  logic               rst_n,
  input  logic               update,
  input  logic [IDX_W-1:0]   last,
`endif
  input  logic [NUM_REQ-1:0] req,
  output logic [IDX_W-1:0]   grant,
  output logic               any
);

`ifdef CACHE_ARB_RR_EN
  logic [IDX_W-1:0] ptr;
  logic             found;

  // Pointer starts at the top index so requester 0 is searched first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      ptr <= IDX_W'(NUM_REQ - 1);
    else if (update) ptr <= last;
  end

  // Search starts one past the last served requester.
  always_comb begin
    grant = '0;
    found = 1'b0;
    any   = |req;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (!found && req[IDX_W'((int'(ptr) + 1 + i) % int'(NUM_REQ))]) begin
        grant = IDX_W'((int'(ptr) + 1 + i) % int'(NUM_REQ));
        found = 1'b1;
      end
    end
  end
`else
  // Scan high to low so the lowest requesting index is the final winner.
  always_comb begin
    grant = '0;
    any   = |req;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (req[IDX_W'(i)]) grant = IDX_W'(i);
    end
  end
`endif

endmodule

// File: rtl/cache_axi_rd_arbiter.sv
// Shares one AXI4 read channel among cache read requesters (one transaction at a time).
// Ports: clk, resetn (async active-low); rd_req/rd_addr/rd_line per requester;
// rd_rdy (AR accepted pulse), ret_valid (return pulse), ret_data (shared line);
// axi (AXI AR/R master).
// Macro CACHE_ARB_RR_EN enables round-robin arbitration in req_arbiter.
module cache_axi_rd_arbiter
  import cache_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned LINE_WORD_NUM = LINE_WORD_NUM_DEF,
  parameter int unsigned ID_WIDTH      = 4
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [NUM_REQ-1:0]            rd_req,
  input  logic [NUM_REQ-1:0][31:0]      rd_addr,
  input  logic [NUM_REQ-1:0]            rd_line,
  output logic [NUM_REQ-1:0]            rd_rdy,
  output logic [NUM_REQ-1:0]            ret_valid,
  output logic [32*LINE_WORD_NUM-1:0]   ret_data,
  cache_axi_rd_arbiter_if.master        axi
);

  localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned BEAT_W = (LINE_WORD_NUM > 1) ? $clog2(LINE_WORD_NUM) : 1;

  arb_state_t                          state, state_nxt;
  logic [IDX_W-1:0]                    grant_q, grant_c;
  logic                                any_c;
  logic [BEAT_W-1:0]                   beat;
  logic [LINE_WORD_NUM-1:0][31:0]      line_buf, buf_nxt;
  logic                                ar_hs;
  logic                                unused_axi;

  req_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
`ifdef CACHE_ARB_RR_EN
    .clk     (clk),
    .rst_n   (resetn),
    .update  (state == RET),
    .last    (grant_q),
`endif
    .req     (rd_req),
    .grant   (grant_c),
    .any     (any_c)
  );

  assign ar_hs       = axi.arvalid && axi.arready;
  assign axi.arsize  = AXI_SIZE_WORD;
  assign axi.arburst = AXI_BURST_INCR;
  // The requester must see acceptance in the handshake cycle itself.
  assign rd_rdy      = ar_hs ? (NUM_REQ'(1) << grant_q) : '0;
  // ID and response are passed through unchecked.
  assign unused_axi  = ^{axi.rid, axi.rresp};

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next state and line-buffer update.
  always_comb begin
    state_nxt = state;
    buf_nxt   = line_buf;
    case (state)
      IDLE:  if (any_c) state_nxt = AR;
      AR:    if (ar_hs) state_nxt = RDATA;
      RDATA: begin
        if (axi.rvalid) begin
          buf_nxt[beat] = axi.rdata;
          if (axi.rlast) state_nxt = RET;
        end
      end
      RET:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered outputs, AR fields and datapath.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      grant_q     <= '0;
      axi.arid    <= '0;
      axi.araddr  <= '0;
      axi.arlen   <= '0;
      axi.arvalid <= 1'b0;
      axi.rready  <= 1'b0;
      ret_valid   <= '0;
      ret_data    <= '0;
      line_buf    <= '0;
      beat        <= '0;
    end else begin
      axi.arvalid <= (state_nxt == AR);
      axi.rready  <= (state_nxt == RDATA);
      ret_valid   <= (state_nxt == RET) ? (NUM_REQ'(1) << grant_q) : '0;
      line_buf    <= buf_nxt;
      // ret_data captures the final beat directly so it is valid in RET.
      if (state_nxt == RET) ret_data <= buf_nxt;
      // AR fields are latched once at grant and stay stable until arready.
      if (state == IDLE && any_c) begin
        grant_q    <= grant_c;
        axi.arid   <= ID_WIDTH'(grant_c);
        if (rd_line[grant_c]) begin
          axi.araddr <= rd_addr[grant_c] & ~32'(4 * LINE_WORD_NUM - 1);
          axi.arlen  <= 8'(LINE_WORD_NUM - 1);
        end else begin
          axi.araddr <= rd_addr[grant_c] & ~32'h3;
          axi.arlen  <= 8'd0;
        end
      end
      if (state == AR && ar_hs) begin
        beat <= '0;
      end else if (state == RDATA && axi.rvalid) begin
        beat <= (beat == BEAT_W'(LINE_WORD_NUM - 1)) ? '0 : beat + BEAT_W'(1);
      end
    end
  end

endmodule

// File: doc/cache_axi_rd_arbiter.md
Name: cache_axi_rd_arbiter

Overview:
Shares one AXI4 read channel (AR/R) between the cache-side read requesters: ICache line refill, ICache uncached fetch, DCache line refill and DCache uncached load. Each requester uses the cache-side handshake `rd_req`/`rd_addr` → `rd_rdy` → `ret_valid`/`ret_data`. The arbiter issues a single AR, collects the R beats into a line buffer and returns the whole line, or one word, to the granted requester. It sits between the cache controllers and the AXI crossbar.

Parameters:
NUM_REQ, 4, number of requesters; index 0 has the highest fixed priority.
LINE_WORD_NUM, 4, 32-bit words per cache line; this is the burst length for line requests.
ID_WIDTH, 4, AXI ID width; must satisfy ID_WIDTH ≥ clog2(NUM_REQ).

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
rd_req  in  NUM_REQ  per-requester read request level
rd_addr  in  NUM_REQ×32  per-requester byte address
rd_line  in  NUM_REQ  1 = line burst, 0 = single uncached word
rd_rdy  out  NUM_REQ  one-cycle pulse: AR accepted for that requester
ret_valid  out  NUM_REQ  one-cycle pulse: ret_data valid for that requester
ret_data  out  32×LINE_WORD_NUM  shared return line; word 0 in bits [31:0]
arid/araddr/arlen/arsize/arburst/arvalid  out  ID_WIDTH/32/8/3/2/1  AXI AR channel
arready  in  1
rid/rdata/rresp/rlast/rvalid  in  ID_WIDTH/32/2/1/1  AXI R channel
rready  out  1

Behaviour:
- Reset is asynchronous, active-low:
  - state = IDLE; grant = 0.
  - arvalid, rready, rd_rdy and ret_valid are 0.
  - ret_data and the line buffer are 0; beat counter is 0.
- FSM states: IDLE → AR → RDATA → RET → IDLE.
- IDLE:
  - If any rd_req is high, register the grant index and latch that requester's addr/line flag, then go to AR.
  - If no rd_req is high, stay in IDLE.
- AR:
  - arvalid = 1.
  - arid = grant.
  - araddr:
    - line request: {addr[31:log2(4·LINE_WORD_NUM)], zeros}.
    - word request: {addr[31:2], 2'b00}.
  - arlen:
    - line request: LINE_WORD_NUM−1.
    - word request: 0.
  - arsize = 3'b010; arburst = INCR.
  - AR fields stay stable until arready.
  - On arvalid & arready: pulse rd_rdy[grant] for that cycle, clear the beat counter, go to RDATA.
- RDATA:
  - rready = 1.
  - Each rvalid beat writes rdata into buffer word[beat] and increments beat; beat wraps modulo LINE_WORD_NUM.
  - rvalid & rlast ends the burst → RET.
  - rid and rresp are not checked; data is passed through.
  - A word request fills word 0 only.
- RET:
  - ret_valid[grant] = 1 for exactly one cycle; ret_data = buffer.
  - Next state is IDLE.
  - ret_data holds until the next RET.
- Latency: rd_req seen in IDLE at cycle 0 → arvalid at cycle 1. The last beat at cycle n → ret_valid at cycle n+1. A new grant is possible at cycle n+2.
- The grant is locked from AR through RET. If a requester drops rd_req mid-transaction, the transaction still completes.
- Requests that arrive while busy wait; rd_req is a level signal and is sampled only in IDLE.
- Early rlast (fewer beats than LINE_WORD_NUM) completes the transaction; unfilled words keep their old contents.
- Only one transaction is outstanding at a time; reads are never interleaved.
- rready is 0 outside RDATA.

Optional Feature:
CACHE_ARB_RR_EN:
- Defined: round-robin arbitration. A last-grant pointer updates in RET; search starts at last+1 mod NUM_REQ.
- Undefined: fixed priority, lowest index wins.
- The pointer resets to NUM_REQ−1, so requester 0 gets the first grant.

Decomposition:
- Package `cache_arb_pkg`:
  - arb_state_t enum {IDLE, AR, RDATA, RET}.
  - AXI_SIZE_WORD = 3'b010.
  - AXI_BURST_INCR = 2'b01.
  - line_t = logic [32·LINE_WORD_NUM−1:0].
- Sub-module `req_arbiter` (NUM_REQ): combinational grant from the request vector plus the optional RR pointer register; outputs grant index and any-request flag.

Test Plan:
- Only req[0] active, line, addr 0x1FC0_0014, arready same cycle, beats 0x11/0x22/0x33/0x44 with rlast on the 4th → araddr 0x1FC0_0010, arlen 3, arid 0; rd_rdy[0] pulses once; ret_valid[0] pulses one cycle after the last beat; ret_data = {0x44,0x33,0x22,0x11}.
- Only req[1] active, word, addr 0xBFC0_0006 → araddr 0xBFC0_0004, arlen 0; one beat 0xDEADBEEF → ret_valid[1]; ret_data[31:0] = 0xDEADBEEF.
- req[0] and req[2] raised in the same cycle, fixed priority → req[0] served first, then req[2] on the following IDLE. With CACHE_ARB_RR_EN and both held: grants alternate 0, 2, 0, 2.
- arready held low 5 cycles → arvalid and araddr stay stable; rd_rdy stays 0 until the handshake cycle.
- rvalid gaps between beats, plus rd_req dropped during RDATA → all 4 words captured in order; ret_valid still pulses.
- resetn asserted low mid-RDATA → arvalid, rready and ret_valid go to 0 immediately; state = IDLE; after release, a fresh request completes normally.
